// File: rtl/rx_word_assembler_pkg.sv
// Shared types and width helpers for the receive-side byte-to-word assembler.
package rx_word_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } collect_state_e;

  // Bits needed to index 0..value-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Counts idle cycles between bytes of one word; flags expiry before a byte arrives.
module rx_idle_timer
  import rx_word_assembler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o_c
);

  localparam int unsigned TMR_W = clog2_min1(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] count_q, count_d;

  // Saturates so a stalled run can never wrap back into range.
  always_comb begin
    count_d = count_q;
    if (!run_i || clear_i) begin
      count_d = '0;
    end else if (count_q != TMR_W'(TIMEOUT_CYC)) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  assign expire_o_c = run_i && !clear_i && (count_q == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/rx_word_assembler.sv
// Packs UART receiver bytes into tagged sample words with a valid/ready output,
// overrun detection and an inter-byte timeout resync.
module rx_word_assembler
  import rx_word_assembler_pkg::*;
#(
  parameter  int unsigned BYTE_W         = 8,
  parameter  int unsigned BYTES_PER_WORD = 2,
  parameter  int unsigned MSB_FIRST      = 1,
  parameter  int unsigned NUM_CH         = 1,
  parameter  int unsigned TIMEOUT_CYC    = 0,
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD,
  localparam int unsigned CH_W           = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic [WORD_W-1:0] word_out,
  output logic [CH_W-1:0]   word_ch,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = clog2_min1(BYTES_PER_WORD);

  collect_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d, word_q;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d, word_ch_q;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              tmo_q, tmo_d;
  logic              last_byte_c, expire_c, complete_c, load_c;

  assign last_byte_c = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  if (TIMEOUT_CYC > 0) begin : g_timer
    rx_idle_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
      .clk       (clk),
      .rst       (rst),
      .run_i     (state_q == ST_COLLECT),
      .clear_i   (rx_ready),
      .expire_o_c(expire_c)
    );
  end else begin : g_no_timer
    assign expire_c = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A strobe always wins over expiry; DONE accepts a strobe exactly like IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rx_ready) begin
      if (last_byte_c) begin
        state_d = ST_DONE;
        cnt_d   = '0;
      end else begin
        state_d = ST_COLLECT;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else if (expire_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    complete_c = 1'b0;
    load_c     = 1'b0;
    overrun_d  = 1'b0;
    tmo_d      = 1'b0;
    complete_c = rx_ready && last_byte_c;
    load_c     = complete_c && (!valid_q || word_ready);
    overrun_d  = complete_c && valid_q && !word_ready;
    tmo_d      = expire_c;
  end

  // Byte k of a word lands in its slice as it arrives; the last byte bypasses asm_q.
  for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_slice
    localparam int unsigned SLICE = (MSB_FIRST != 0) ? (BYTES_PER_WORD - 1 - k) : k;
    assign asm_d[SLICE*BYTE_W +: BYTE_W] = (rx_ready && (cnt_q == CNT_W'(k)))
                                           ? rx_data : asm_q[SLICE*BYTE_W +: BYTE_W];
  end

  always_comb begin
    valid_d  = valid_q;
    ch_cnt_d = ch_cnt_q;
    if (load_c) begin
      valid_d  = 1'b1;
      ch_cnt_d = (ch_cnt_q == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt_q + CH_W'(1);
    end else if (word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q     <= '0;
      word_q    <= '0;
      word_ch_q <= '0;
      ch_cnt_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      ch_cnt_q  <= ch_cnt_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      tmo_q     <= tmo_d;
      if (load_c) begin
        word_q    <= asm_d;
        word_ch_q <= ch_cnt_q;
      end
    end
  end

  assign word_out    = word_q;
  assign word_ch     = word_ch_q;
  assign word_valid  = valid_q;
  assign overrun     = overrun_q;
  assign timeout_err = tmo_q;

endmodule
